// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator / capture pair.
//   capture_state_t : capture FSM state encoding
//   PWM_WIDTH       : common counter width shared with the generator
//   PWM_SYNC_STAGES : default synchroniser depth for asynchronous PWM inputs
// ----------------------------------------------------------------------------
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } capture_state_t;

   localparam int unsigned PWM_WIDTH       = 16;
   localparam int unsigned PWM_SYNC_STAGES = 2;

endpackage : pwm_pkg

// File: rtl/pwm_sync.sv
// ----------------------------------------------------------------------------
// pwm_sync
// Multi-flop synchroniser for an asynchronous PWM input plus an edge detector.
// Rise and fall are both derived from the same synchronised level and its
// one-cycle delayed copy, so both edges carry identical latency.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset (all flops to 0)
//   async_i : asynchronous input
//   s_o     : synchronised level
//   rise_o  : one-cycle strobe, synchronised level went 0 -> 1
//   fall_o  : one-cycle strobe, synchronised level went 1 -> 0
// ----------------------------------------------------------------------------
module pwm_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic s_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_dly_q;

   // Synchroniser chain and one-cycle delayed copy of its output
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= {SYNC_STAGES{1'b0}};
         s_dly_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
         s_dly_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~s_dly_q;
   assign fall_o = ~sync_q[SYNC_STAGES-1] & s_dly_q;

endmodule : pwm_sync

// File: rtl/pwm_capture.sv
// ----------------------------------------------------------------------------
// pwm_capture
// Measures high time and rise-to-rise period of an asynchronous PWM input in
// MClk cycles. Each completed period is published with a one-cycle Valid
// strobe; a period that never completes raises the sticky Timeout flag.
// Ports:
//   MClk        : system clock, all logic on its rising edge
//   nRst        : asynchronous active-low reset
//   Enable      : measurement enable; low returns the FSM to IDLE
//   PwmIn       : asynchronous PWM signal
//   HighCount   : high time of the last complete period
//   PeriodCount : rise-to-rise time of the last complete period
//   Valid       : one-cycle strobe, results updated this cycle
//   Timeout     : sticky, no rise seen for 2^WIDTH-1 cycles
//   StuckLevel  : synchronised input level when Timeout was set
// ----------------------------------------------------------------------------
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH       = PWM_WIDTH,
   parameter int unsigned SYNC_STAGES = PWM_SYNC_STAGES
) (
   input  logic             MClk,
   input  logic             nRst,
   input  logic             Enable,
   input  logic             PwmIn,
   output logic [WIDTH-1:0] HighCount,
   output logic [WIDTH-1:0] PeriodCount,
   output logic             Valid,
   output logic             Timeout,
   output logic             StuckLevel
);

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

   logic           sig_s;
   logic           rise_s;
   logic           fall_s;
   logic           timeout_hit_s;

   capture_state_t state_q;
   logic [WIDTH-1:0] cnt_per_q, cnt_per_d;
   logic [WIDTH-1:0] cnt_hi_q,  cnt_hi_d;
   logic [WIDTH-1:0] hi_latch_q;
   logic [WIDTH-1:0] high_count_q;
   logic [WIDTH-1:0] period_count_q;
   logic             valid_q;
   logic             timeout_q;
   logic             stuck_level_q;

   pwm_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i   (MClk),
      .rst_ni  (nRst),
      .async_i (PwmIn),
      .s_o     (sig_s),
      .rise_o  (rise_s),
      .fall_o  (fall_s)
   );

   // A rise in the same cycle as counter saturation is a legal measurement,
   // so the rise suppresses the timeout.
   assign timeout_hit_s = (state_q != IDLE) && (cnt_per_q == CNT_MAX) && !rise_s;

   // Next-state of the period and high-time counters (saturating)
   always_comb begin
      cnt_per_d = cnt_per_q;
      cnt_hi_d  = cnt_hi_q;
      if (!Enable || (state_q == IDLE) || timeout_hit_s) begin
         cnt_per_d = CNT_ZERO;
         cnt_hi_d  = CNT_ZERO;
      end else if (rise_s) begin
         cnt_per_d = CNT_ONE;
         cnt_hi_d  = CNT_ONE;
      end else begin
         if (cnt_per_q != CNT_MAX) begin
            cnt_per_d = cnt_per_q + CNT_ONE;
         end else begin
            cnt_per_d = cnt_per_q;
         end
         if (sig_s && (cnt_hi_q != CNT_MAX)) begin
            cnt_hi_d = cnt_hi_q + CNT_ONE;
         end else begin
            cnt_hi_d = cnt_hi_q;
         end
      end
   end

   // Counter registers
   always_ff @(posedge MClk or negedge nRst) begin
      if (!nRst) begin
         cnt_per_q <= CNT_ZERO;
         cnt_hi_q  <= CNT_ZERO;
      end else begin
         cnt_per_q <= cnt_per_d;
         cnt_hi_q  <= cnt_hi_d;
      end
   end

   // Capture FSM with registered result, strobe and status outputs
   always_ff @(posedge MClk or negedge nRst) begin
      if (!nRst) begin
         state_q        <= IDLE;
         hi_latch_q     <= CNT_ZERO;
         high_count_q   <= CNT_ZERO;
         period_count_q <= CNT_ZERO;
         valid_q        <= 1'b0;
         timeout_q      <= 1'b0;
         stuck_level_q  <= 1'b0;
      end else if (!Enable) begin
         // Results are kept so software can still read the last measurement
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q <= ARM;
            end
            ARM: begin
               // Whatever was in flight at enable is discarded; start on a rise
               if (rise_s) begin
                  state_q <= HIGH;
               end else if (timeout_hit_s) begin
                  timeout_q     <= 1'b1;
                  stuck_level_q <= sig_s;
                  state_q       <= ARM;
               end else begin
                  state_q <= ARM;
               end
            end
            HIGH: begin
               if (timeout_hit_s) begin
                  timeout_q     <= 1'b1;
                  stuck_level_q <= sig_s;
                  state_q       <= ARM;
               end else if (fall_s) begin
                  hi_latch_q <= cnt_hi_q;
                  state_q    <= LOW;
               end else begin
                  state_q <= HIGH;
               end
            end
            LOW: begin
               // cnt_per_q still holds the pre-reload count of the ending period
               if (rise_s) begin
                  high_count_q   <= hi_latch_q;
                  period_count_q <= cnt_per_q;
                  valid_q        <= 1'b1;
                  timeout_q      <= 1'b0;
                  state_q        <= HIGH;
               end else if (timeout_hit_s) begin
                  timeout_q     <= 1'b1;
                  stuck_level_q <= sig_s;
                  state_q       <= ARM;
               end else begin
                  state_q <= LOW;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign HighCount   = high_count_q;
   assign PeriodCount = period_count_q;
   assign Valid       = valid_q;
   assign Timeout     = timeout_q;
   assign StuckLevel  = stuck_level_q;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// ----------------------------------------------------------------------------
// tb_pwm_capture
// Directed bench for pwm_capture (WIDTH=8 so timeouts occur within 255 cycles).
// PwmIn is normally driven 2 ns after the rising MClk edge so every high/low
// run lasts an exact number of cycles; the last test uses an arbitrary phase.
// ----------------------------------------------------------------------------
module tb_pwm_capture;

   localparam int unsigned W = 8;

   logic         MClk;
   logic         nRst;
   logic         Enable;
   logic         PwmIn;
   logic [W-1:0] HighCount;
   logic [W-1:0] PeriodCount;
   logic         Valid;
   logic         Timeout;
   logic         StuckLevel;

   int n_checks;
   int n_fail;
   int wide_cnt;
   logic valid_prev;
   int   vhi[$];
   int   vper[$];

   pwm_capture #(
      .WIDTH       (W),
      .SYNC_STAGES (2)
   ) dut (
      .MClk        (MClk),
      .nRst        (nRst),
      .Enable      (Enable),
      .PwmIn       (PwmIn),
      .HighCount   (HighCount),
      .PeriodCount (PeriodCount),
      .Valid       (Valid),
      .Timeout     (Timeout),
      .StuckLevel  (StuckLevel)
   );

   initial MClk = 1'b0;
   always #5 MClk = ~MClk;

   // Record every Valid strobe and detect strobes wider than one cycle
   initial begin
      valid_prev = 1'b0;
      wide_cnt   = 0;
      forever begin
         @(negedge MClk);
         if (Valid === 1'b1) begin
            vhi.push_back(int'(HighCount));
            vper.push_back(int'(PeriodCount));
            if (valid_prev) wide_cnt++;
         end
         valid_prev = (Valid === 1'b1);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic level, input int n);
      PwmIn = level;
      repeat (n) begin
         @(posedge MClk);
         #2;
      end
   endtask

   task automatic clear_log();
      vhi.delete();
      vper.delete();
   endtask

   task automatic check_result(input string tag, input int idx, input int hi, input int per);
      if (idx < vhi.size()) begin
         check_eq({tag, "_hi"}, 32'(vhi[idx]), 32'(hi));
         check_eq({tag, "_per"}, 32'(vper[idx]), 32'(per));
      end else begin
         check_eq({tag, "_missing"}, 32'(vhi.size()), 32'(idx + 1));
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_hc"}, 32'(HighCount), 32'd0);
      check_eq({tag, "_pc"}, 32'(PeriodCount), 32'd0);
      check_eq({tag, "_valid"}, 32'(Valid), 32'd0);
      check_eq({tag, "_tmo"}, 32'(Timeout), 32'd0);
      check_eq({tag, "_stuck"}, 32'(StuckLevel), 32'd0);
   endtask

   initial begin
      int ph;
      int sum;
      n_checks = 0;
      n_fail   = 0;
      nRst     = 1'b0;
      Enable   = 1'b0;
      PwmIn    = 1'b0;
      repeat (3) @(posedge MClk);
      #2;
      check_outputs_zero("reset");
      nRst = 1'b1;
      hold(1'b0, 2);

      // 1: 30/70 for three periods, first rise only arms
      Enable = 1'b1;
      hold(1'b0, 5);
      clear_log();
      for (int p = 0; p < 3; p++) begin
         hold(1'b1, 30);
         hold(1'b0, 70);
      end
      hold(1'b0, 10);
      check_eq("t1_count", 32'(vhi.size()), 32'd2);
      check_result("t1_v0", 0, 30, 100);
      check_result("t1_v1", 1, 30, 100);
      check_eq("t1_tmo", 32'(Timeout), 32'd0);

      // 2: last period stretched to 110, then 1/1 and 99/1
      clear_log();
      hold(1'b1, 1);
      hold(1'b0, 1);
      hold(1'b1, 99);
      hold(1'b0, 1);
      hold(1'b1, 5);
      hold(1'b0, 10);
      check_eq("t2_count", 32'(vhi.size()), 32'd3);
      check_result("t2_v0", 0, 30, 110);
      check_result("t2_v1", 1, 1, 2);
      check_result("t2_v2", 2, 99, 100);
      check_eq("t2_wide", 32'(wide_cnt), 32'd0);

      // 3: stuck high, recover with 10/10, then stuck low
      clear_log();
      hold(1'b1, 300);
      check_eq("t3_tmo_hi", 32'(Timeout), 32'd1);
      check_eq("t3_stuck_hi", 32'(StuckLevel), 32'd1);
      check_eq("t3_count_a", 32'(vhi.size()), 32'd1);
      check_result("t3_v0", 0, 5, 15);
      hold(1'b0, 10);
      hold(1'b1, 10);
      hold(1'b0, 10);
      check_eq("t3_count_b", 32'(vhi.size()), 32'd1);
      hold(1'b1, 2);
      hold(1'b0, 5);
      check_eq("t3_count_c", 32'(vhi.size()), 32'd2);
      check_result("t3_v1", 1, 10, 20);
      check_eq("t3_tmo_clr", 32'(Timeout), 32'd0);
      hold(1'b0, 300);
      check_eq("t3_tmo_lo", 32'(Timeout), 32'd1);
      check_eq("t3_stuck_lo", 32'(StuckLevel), 32'd0);
      check_eq("t3_count_d", 32'(vhi.size()), 32'd2);

      // 4: Enable dropped mid-HIGH keeps results, re-arms
      hold(1'b1, 20);
      hold(1'b0, 20);
      hold(1'b1, 20);
      check_eq("t4_hc", 32'(HighCount), 32'd20);
      check_eq("t4_pc", 32'(PeriodCount), 32'd40);
      check_eq("t4_tmo", 32'(Timeout), 32'd0);
      Enable = 1'b0;
      hold(1'b1, 3);
      check_eq("t4_hc_kept", 32'(HighCount), 32'd20);
      check_eq("t4_pc_kept", 32'(PeriodCount), 32'd40);
      Enable = 1'b1;
      clear_log();
      hold(1'b1, 5);
      hold(1'b0, 15);
      hold(1'b1, 10);
      hold(1'b0, 10);
      check_eq("t4_no_valid", 32'(vhi.size()), 32'd0);
      hold(1'b1, 5);
      check_eq("t4_count", 32'(vhi.size()), 32'd1);
      check_result("t4_v0", 0, 10, 20);

      // 5: asynchronous reset in LOW
      hold(1'b0, 10);
      nRst = 1'b0;
      #1;
      check_outputs_zero("t5_async");
      hold(1'b0, 3);
      nRst = 1'b1;
      clear_log();
      hold(1'b0, 5);
      hold(1'b1, 10);
      hold(1'b0, 10);
      check_eq("t5_no_valid", 32'(vhi.size()), 32'd0);
      hold(1'b1, 5);
      check_eq("t5_count", 32'(vhi.size()), 32'd1);
      check_result("t5_v0", 0, 10, 20);

      // 6: 40/60 at an arbitrary phase to MClk
      hold(1'b0, 10);
      Enable = 1'b0;
      hold(1'b0, 2);
      Enable = 1'b1;
      hold(1'b0, 3);
      clear_log();
      ph = int'($urandom_range(1, 9));
      @(posedge MClk);
      #(ph);
      for (int p = 0; p < 9; p++) begin
         PwmIn = 1'b1;
         #400;
         PwmIn = 1'b0;
         #600;
      end
      repeat (10) @(posedge MClk);
      #2;
      check_eq("t6_count", 32'(vhi.size()), 32'd8);
      sum = 0;
      for (int i = 0; i < vhi.size(); i++) begin
         check_eq($sformatf("t6_per%0d", i), 32'(vper[i]), 32'd100);
         check_eq($sformatf("t6_hi%0d_range", i), 32'((vhi[i] >= 39) && (vhi[i] <= 41)), 32'd1);
         sum += vper[i];
      end
      check_eq("t6_sum", 32'(sum), 32'd800);
      check_eq("t6_wide", 32'(wide_cnt), 32'd0);
      check_eq("t6_tmo", 32'(Timeout), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pwm_capture
